// File: rtl/aes_pid_scheduler.sv
// Packs eight PID samples into a 128-bit plaintext block, drives the shared AES input,
// waits a fixed settle time and hands the selected ciphertext downstream over valid/ready.
module aes_pid_scheduler #(
    parameter int unsigned AES_WAIT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_valid_i,
    input  logic [2:0]   sample_ch_i,
    input  logic [15:0]  sample_data_i,
    input  logic [1:0]   key_sel_i,
    output logic [127:0] aes_input_o,
    input  logic [127:0] aes_out128_i,
    input  logic [127:0] aes_out192_i,
    input  logic [127:0] aes_out256_i,
    output logic         ct_valid_o,
    input  logic         ct_ready_i,
    output logic [127:0] ct_data_o,
    output logic [1:0]   ct_key_o,
    output logic         busy_o,
    output logic         drop_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(AES_WAIT - 1);

    function automatic logic [127:0] select_ct(input logic [1:0] key,
                                               input logic [127:0] ct128,
                                               input logic [127:0] ct192,
                                               input logic [127:0] ct256);
        case (key)
            2'd0:    select_ct = ct128;
            2'd1:    select_ct = ct192;
            2'd2:    select_ct = ct256;
            default: select_ct = ct128;
        endcase
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   mask_q, mask_d;
    logic [127:0] buf_q, buf_d;
    logic [1:0]   key_q, key_d;
    logic [127:0] aes_in_q, aes_in_d;
    logic [127:0] ct_data_q, ct_data_d;
    logic [1:0]   ct_key_q, ct_key_d;
    logic         ct_valid_q, ct_valid_d;
    logic         busy_q, busy_d;
    logic         drop_q, drop_d;

    logic         full_s;
    logic         launch_s;
    logic         accept_s;
    logic [6:0]   slot_lsb_s;

    // A full buffer still accepts a sample on the launch cycle: it lands in the cleared mask.
    assign full_s     = (mask_q == 8'hFF);
    assign launch_s   = (state_q == S_IDLE) && full_s;
    assign accept_s   = sample_valid_i && (!full_s || launch_s);
    assign slot_lsb_s = {3'd7 - sample_ch_i, 4'd0};
    assign busy_d     = (state_d != S_IDLE);
    assign drop_d     = sample_valid_i && !accept_s;

    // Next-state logic for the sequencer and the collection buffer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        buf_d      = buf_q;
        key_d      = key_q;
        aes_in_d   = aes_in_q;
        ct_data_d  = ct_data_q;
        ct_key_d   = ct_key_q;
        ct_valid_d = ct_valid_q;

        case (state_q)
            S_IDLE: begin
                if (full_s) begin
                    aes_in_d = buf_q;
                    key_d    = (key_sel_i == 2'd3) ? 2'd0 : key_sel_i;
                    cnt_d    = WAIT_INIT;
                    state_d  = S_WAIT;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    ct_data_d  = select_ct(key_q, aes_out128_i, aes_out192_i, aes_out256_i);
                    ct_key_d   = key_q;
                    ct_valid_d = 1'b1;
                    state_d    = S_OUT;
                end else begin
                    cnt_d      = cnt_q - 4'd1;
                end
            end
            S_OUT: begin
                if (ct_ready_i) begin
                    ct_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    ct_valid_d = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                ct_valid_d = 1'b0;
            end
        endcase

        if (launch_s) begin
            mask_d = 8'h00;
        end else begin
            mask_d = mask_q;
        end

        if (accept_s) begin
            buf_d[slot_lsb_s +: 16] = sample_data_i;
            mask_d[sample_ch_i]     = 1'b1;
        end else begin
            buf_d = buf_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            mask_q     <= 8'h00;
            buf_q      <= 128'd0;
            key_q      <= 2'd0;
            aes_in_q   <= 128'd0;
            ct_data_q  <= 128'd0;
            ct_key_q   <= 2'd0;
            ct_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            buf_q      <= buf_d;
            key_q      <= key_d;
            aes_in_q   <= aes_in_d;
            ct_data_q  <= ct_data_d;
            ct_key_q   <= ct_key_d;
            ct_valid_q <= ct_valid_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign aes_input_o = aes_in_q;
    assign ct_data_o   = ct_data_q;
    assign ct_key_o    = ct_key_q;
    assign ct_valid_o  = ct_valid_q;
    assign busy_o      = busy_q;
    assign drop_o      = drop_q;

endmodule

// File: doc/aes_pid_scheduler.md
# aes_pid_scheduler

Sequencer between the PID controller bank and the three AES_Encrypt instances (128/192/256-bit keys). Collects eight 16-bit PID control samples into a 128-bit plaintext block, presents it to the shared AES input bus and waits a fixed settle time. It then captures the ciphertext from the key-size instance selected for that block and hands it downstream on a valid/ready interface. A collection buffer in front of the encryption stage lets sampling continue while a block is in flight.

## Interface
- AES_WAIT, 2, cycles the AES input is held before ciphertext capture; legal range 1..15.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  sample write strobe.
- sample_ch  in  3  channel index 0..7 of sample_data.
- sample_data  in  16  PID control_signal value.
- key_sel  in  2  key size for next launched block: 0=128, 1=192, 2=256, 3=reserved.
- aes_input  out  128  plaintext driven to all three AES instances.
- aes_out128 / aes_out192 / aes_out256  in  128 each  ciphertext from the respective instance.
- ct_valid  out  1  ciphertext available.
- ct_ready  in  1  downstream accept.
- ct_data  out  128  captured ciphertext.
- ct_key  out  2  key_sel used for ct_data (3 reported as 0).
- busy  out  1  state != IDLE.
- drop  out  1  one-cycle pulse: sample discarded.

## Operation
- Collection buffer: eight 16-bit slots plus 8-bit fill mask. Channel k occupies bits [127-16k : 112-16k], so ch0 is the MSB word.
- Accepted sample writes its slot and sets mask[k]. A rewrite of a filled slot before launch overwrites the value; the mask is unchanged.
- Buffer full = mask == 8'hFF.
- FSM states: IDLE, WAIT, OUT.
- IDLE: if full, launch:
  - aes_input <= buffer; latch key_sel (3 -> 0); mask <= 0; counter <= AES_WAIT-1; go to WAIT.
  - Buffer slot contents are retained; only the mask clears.
- WAIT: if counter == 0, capture mux(aes_out128/192/256 by latched key) into ct_data, set ct_key, set ct_valid, go to OUT. Otherwise decrement the counter.
- OUT: hold ct_valid, ct_data and ct_key stable. On ct_valid && ct_ready, clear ct_valid and return to IDLE.
- aes_input holds its value until the next launch.
- Sample acceptance, in every state:
  - Accepted if mask != FF, or a launch occurs that same cycle. On a launch cycle the sample lands in the freshly cleared mask, and the launched block uses the pre-edge buffer contents.
  - Otherwise the sample is discarded and drop pulses for one cycle.
- key_sel is sampled only at launch; changes at other times have no effect.

## Timing
- Reset values: aes_input 0, ct_data 0, ct_key 0, ct_valid 0, busy 0, drop 0, mask 0, slots 0, state IDLE.
- Reset assertion mid-block abandons the block immediately; no ciphertext is emitted.
- Latency:
  - Last sample accepted at edge E0.
  - Launch at E1 (aes_input valid after E1).
  - Capture at E1+AES_WAIT.
  - ct_valid high from edge E0+AES_WAIT+1; with default 2, that is 3 cycles after the last sample.
- Handshake: transfer on any rising edge with ct_valid && ct_ready.
  - ct_ready may be high before ct_valid.
  - ct_valid never drops without a transfer.
- Minimum block-to-block spacing: AES_WAIT+2 cycles. IDLE is a one-cycle bubble after each transfer, so a full buffer waiting there launches on the next edge.
- drop is registered; it is high in the cycle after the discarded write.
- Back-to-back launches with continuous ct_ready and a pre-filled buffer: one launch every AES_WAIT+2 cycles.

## Test plan
- Reset, then write ch0..7 = 16'h0001..16'h0008 with key_sel=0 and AES_WAIT=2:
  - aes_input = 128'h0001000200030004000500060007_0008.
  - ct_valid rises 3 cycles after the ch7 write; ct_data == aes_out128; ct_key=0.
- key_sel=2 at launch and key_sel=0 afterwards: ct_data == aes_out256 and ct_key=2.
- key_sel=3 at launch: ct_data == aes_out128 and ct_key=0.
- ct_ready held low for 10 cycles while a second block fills and a 9th sample arrives:
  - ct_data stays stable; the 9th sample pulses drop.
  - After ct_ready, the second block launches after the one-cycle IDLE bubble.
- Sample written on the launch cycle: the first block is unaffected and mask shows that single bit set.
- Overwrite ch3 twice before full: the second value is used and there is no early launch.
- Assert rst_n low during WAIT: outputs at reset values and no ct_valid; a fresh 8-sample fill after release encrypts normally.
